// File: rtl/ram_bus_arbiter.sv
// Two-master RAM arbiter: a boot/DMA loader and a CPU share one
// single-port RAM. The loader owns the bus at boot; afterwards the two
// masters alternate, with a bounded loader burst while the CPU waits.
//
// state   | meaning
// IDLE    | nobody owns the bus; pick the next owner
// LDR_OWN | loader drives the RAM port
// CPU_OWN | CPU drives the RAM port, one access per CPU_REQ cycle
// TURN    | one dead cycle between owners, RAM disabled
module ram_bus_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_BURST     = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     LDR_REQ,
  input  logic [ADDRESS_WIDTH-1:0] LDR_ADDR,
  input  logic [DATA_WIDTH-1:0]    LDR_WDATA,
  input  logic                     LDR_RW,
  input  logic                     LDR_VALID,
  output logic                     LDR_GNT,
  input  logic                     CPU_REQ,
  input  logic [ADDRESS_WIDTH-1:0] CPU_ADDR,
  input  logic [DATA_WIDTH-1:0]    CPU_WDATA,
  input  logic                     CPU_RW,
  output logic                     CPU_GNT,
  output logic                     HALT,
  output logic                     RAM_EN,
  output logic                     RAM_RW,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0]    RAM_WDATA,
  input  logic [DATA_WIDTH-1:0]    RAM_RDATA,
  output logic [DATA_WIDTH-1:0]    RDATA,
  output logic                     LDR_RVALID,
  output logic                     CPU_RVALID
);

  typedef enum logic [1:0] {IDLE, LDR_OWN, CPU_OWN, TURN} state_t;

  localparam logic [5:0] BURST_MAX6 = 6'(MAX_BURST);
  localparam logic [4:0] BURST_MAX5 = 5'(MAX_BURST);

  state_t                state_q, state_d;
  logic                  boot_q, boot_d;
  logic                  cpu_prio_q, cpu_prio_d;
  logic [4:0]            burst_q, burst_d;
  logic                  ldr_rvalid_q, ldr_rvalid_d;
  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // The CPU is invisible to the arbiter until the boot image is loaded.
  logic       cpu_req_eff;
  logic [5:0] burst_inc;
  logic       burst_hit;

  assign cpu_req_eff = CPU_REQ & ~boot_q;
  assign burst_inc   = {1'b0, burst_q} + 6'(LDR_VALID & cpu_req_eff);
  assign burst_hit   = (burst_inc >= BURST_MAX6);

  // Next-state, boot flag, CPU turnover priority and burst counter.
  always_comb begin
    state_d    = state_q;
    boot_d     = boot_q;
    cpu_prio_d = cpu_prio_q;
    burst_d    = '0;
    case (state_q)
      IDLE: begin
        if (cpu_prio_q && cpu_req_eff) state_d = CPU_OWN;
        else if (LDR_REQ)              state_d = LDR_OWN;
        else if (cpu_req_eff)          state_d = CPU_OWN;
        if (!cpu_req_eff) cpu_prio_d = 1'b0;
      end
      LDR_OWN: begin
        if (!LDR_REQ) begin
          state_d = TURN;
          boot_d  = 1'b0;
        end else if (cpu_req_eff && burst_hit) begin
          // Forced turnover: the CPU gets one access before the loader returns.
          state_d    = TURN;
          cpu_prio_d = 1'b1;
        end else begin
          burst_d = burst_hit ? BURST_MAX5 : burst_inc[4:0];
        end
      end
      CPU_OWN: begin
        if (CPU_REQ) cpu_prio_d = 1'b0;
        if (!CPU_REQ || LDR_REQ) state_d = TURN;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants, RAM port mux and CPU stall, all combinational from the owner.
  always_comb begin
    LDR_GNT   = 1'b0;
    CPU_GNT   = 1'b0;
    RAM_EN    = 1'b0;
    RAM_RW    = 1'b1;
    RAM_ADDR  = '0;
    RAM_WDATA = '0;
    case (state_q)
      LDR_OWN: begin
        LDR_GNT   = 1'b1;
        RAM_EN    = LDR_VALID;
        RAM_RW    = LDR_RW;
        RAM_ADDR  = LDR_ADDR;
        RAM_WDATA = LDR_WDATA;
      end
      CPU_OWN: begin
        CPU_GNT   = CPU_REQ;
        RAM_EN    = CPU_REQ;
        RAM_RW    = CPU_RW;
        RAM_ADDR  = CPU_ADDR;
        RAM_WDATA = CPU_WDATA;
      end
      default: ;
    endcase
    HALT = boot_q | (CPU_REQ & ~CPU_GNT);
  end

  // Read tagging: remember who issued a read so its data can be steered next cycle.
  always_comb begin
    ldr_rvalid_d = (state_q == LDR_OWN) & LDR_VALID & LDR_RW;
    cpu_rvalid_d = (state_q == CPU_OWN) & CPU_REQ & CPU_RW;
    rdata_d      = (ldr_rvalid_q | cpu_rvalid_q) ? RAM_RDATA : rdata_q;
  end

  assign LDR_RVALID = ldr_rvalid_q;
  assign CPU_RVALID = cpu_rvalid_q;
  // Pass RAM data straight through on a returning read, otherwise hold the last word.
  assign RDATA      = rdata_d;

  // State and datapath registers; reset aborts any outstanding read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      boot_q       <= 1'b1;
      cpu_prio_q   <= 1'b0;
      burst_q      <= '0;
      ldr_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      boot_q       <= boot_d;
      cpu_prio_q   <= cpu_prio_d;
      burst_q      <= burst_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a small behavioural RAM.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_ram_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        ldr_req, ldr_rw, ldr_valid, ldr_gnt;
  logic [15:0] ldr_addr, ldr_wdata;
  logic        cpu_req, cpu_rw, cpu_gnt, halt;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        ram_en, ram_rw;
  logic [15:0] ram_addr, ram_wdata, ram_rdata, rdata;
  logic        ldr_rvalid, cpu_rvalid;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic [15:0] boot_addr [3];
  logic [15:0] boot_data [3];
  logic [2:0]  burst_exp [11];
  logic [4:0]  cont_vec  [11];

  ram_bus_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .MAX_BURST(4)) dut (
    .CLK(clk), .RESET(rst),
    .LDR_REQ(ldr_req), .LDR_ADDR(ldr_addr), .LDR_WDATA(ldr_wdata),
    .LDR_RW(ldr_rw), .LDR_VALID(ldr_valid), .LDR_GNT(ldr_gnt),
    .CPU_REQ(cpu_req), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_RW(cpu_rw), .CPU_GNT(cpu_gnt), .HALT(halt),
    .RAM_EN(ram_en), .RAM_RW(ram_rw), .RAM_ADDR(ram_addr),
    .RAM_WDATA(ram_wdata), .RAM_RDATA(ram_rdata),
    .RDATA(rdata), .LDR_RVALID(ldr_rvalid), .CPU_RVALID(cpu_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: one-cycle read latency, preloaded while reset is high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
      mem[8'h0D] <= 16'h6006;
      ram_rdata  <= 16'h0000;
    end else if (ram_en) begin
      if (ram_rw) ram_rdata <= mem[ram_addr[7:0]];
      else        mem[ram_addr[7:0]] <= ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_halt"},   halt, 1);
    check({tag, "_lgnt"},   ldr_gnt, 0);
    check({tag, "_cgnt"},   cpu_gnt, 0);
    check({tag, "_en"},     ram_en, 0);
    check({tag, "_rw"},     ram_rw, 1);
    check({tag, "_addr"},   ram_addr, 0);
    check({tag, "_wdata"},  ram_wdata, 0);
    check({tag, "_rdata"},  rdata, 0);
    check({tag, "_lrv"},    ldr_rvalid, 0);
    check({tag, "_crv"},    cpu_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    boot_addr[0] = 16'h0010; boot_data[0] = 16'h0005;
    boot_addr[1] = 16'h0011; boot_data[1] = 16'h0000;
    boot_addr[2] = 16'h0012; boot_data[2] = 16'h0001;
    // burst limit: {ldr_gnt, cpu_gnt, ram_en} per cycle from IDLE
    burst_exp[0] = 3'b000; burst_exp[1] = 3'b101; burst_exp[2] = 3'b101;
    burst_exp[3] = 3'b101; burst_exp[4] = 3'b101; burst_exp[5] = 3'b000;
    burst_exp[6] = 3'b000; burst_exp[7] = 3'b011; burst_exp[8] = 3'b000;
    burst_exp[9] = 3'b000; burst_exp[10] = 3'b101;
    // contention: {ldr_req, cpu_req, ldr_gnt, cpu_gnt, ram_en}
    cont_vec[0] = 5'b11000; cont_vec[1] = 5'b11100; cont_vec[2] = 5'b11100;
    cont_vec[3] = 5'b01100; cont_vec[4] = 5'b01000; cont_vec[5] = 5'b01000;
    cont_vec[6] = 5'b01011; cont_vec[7] = 5'b10000; cont_vec[8] = 5'b10000;
    cont_vec[9] = 5'b10000; cont_vec[10] = 5'b10100;

    rst = 1'b1;
    ldr_req = 0; ldr_rw = 1; ldr_valid = 0; ldr_addr = 0; ldr_wdata = 0;
    cpu_req = 0; cpu_rw = 1; cpu_addr = 0; cpu_wdata = 0;
    #2;
    check_reset_outputs("rst");
    tick();
    tick();
    rst = 1'b0;

    // CPU before boot load: ignored entirely
    cpu_req = 1; cpu_rw = 0; cpu_addr = 16'h0055; cpu_wdata = 16'h00AA;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("preboot_cgnt", cpu_gnt, 0);
      check("preboot_halt", halt, 1);
      check("preboot_en", ram_en, 0);
      tick();
    end
    cpu_req = 0;

    // Boot load
    ldr_req = 1;
    mid();
    check("boot_idle_lgnt", ldr_gnt, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      ldr_valid = 1; ldr_rw = 0; ldr_addr = boot_addr[i]; ldr_wdata = boot_data[i];
      mid();
      check("boot_lgnt", ldr_gnt, 1);
      check("boot_en", ram_en, 1);
      check("boot_rw", ram_rw, 0);
      check("boot_addr", ram_addr, boot_addr[i]);
      check("boot_wdata", ram_wdata, boot_data[i]);
      check("boot_halt", halt, 1);
      tick();
    end
    ldr_valid = 0; ldr_req = 0;
    mid();
    check("boot_fall_lgnt", ldr_gnt, 1);
    check("boot_fall_en", ram_en, 0);
    check("boot_fall_halt", halt, 1);
    tick();
    mid();
    check("turn_lgnt", ldr_gnt, 0);
    check("turn_en", ram_en, 0);
    check("turn_rw", ram_rw, 1);
    tick();
    mid();
    check("postboot_halt", halt, 0);
    check("mem_10", mem[8'h10], 16'h0005);
    check("mem_11", mem[8'h11], 16'h0000);
    check("mem_12", mem[8'h12], 16'h0001);
    tick();

    // CPU read tagging
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h000D;
    mid();
    check("rd_idle_cgnt", cpu_gnt, 0);
    check("rd_idle_halt", halt, 1);
    tick();
    mid();
    check("rd_cgnt", cpu_gnt, 1);
    check("rd_en", ram_en, 1);
    check("rd_rw", ram_rw, 1);
    check("rd_addr", ram_addr, 16'h000D);
    check("rd_halt", halt, 0);
    check("rd_crv_early", cpu_rvalid, 0);
    tick();
    cpu_req = 0;
    mid();
    check("rd_crv", cpu_rvalid, 1);
    check("rd_lrv", ldr_rvalid, 0);
    check("rd_data", rdata, 16'h6006);
    tick();
    mid();
    check("rd_crv_after", cpu_rvalid, 0);
    check("rd_lrv_after", ldr_rvalid, 0);
    check("rd_hold", rdata, 16'h6006);
    tick();

    // Burst limit with MAX_BURST = 4
    ldr_req = 1; ldr_valid = 1; ldr_rw = 0; ldr_addr = 16'h0030; ldr_wdata = 16'h1234;
    cpu_req = 1; cpu_rw = 0; cpu_addr = 16'h0020; cpu_wdata = 16'hBEEF;
    for (int i = 0; i < 11; i++) begin
      mid();
      check($sformatf("burst%0d_lgnt", i), ldr_gnt, burst_exp[i][2]);
      check($sformatf("burst%0d_cgnt", i), cpu_gnt, burst_exp[i][1]);
      check($sformatf("burst%0d_en", i), ram_en, burst_exp[i][0]);
      tick();
    end
    check("burst_cpu_write", mem[8'h20], 16'hBEEF);
    ldr_req = 0; ldr_valid = 0; cpu_req = 0;
    tick();
    tick();
    tick();

    // Contention in IDLE, then simultaneous LDR_REQ rise / CPU_REQ fall
    ldr_valid = 0; ldr_rw = 1; cpu_rw = 0;
    for (int i = 0; i < 11; i++) begin
      ldr_req = cont_vec[i][4];
      cpu_req = cont_vec[i][3];
      mid();
      check($sformatf("cont%0d_lgnt", i), ldr_gnt, cont_vec[i][2]);
      check($sformatf("cont%0d_cgnt", i), cpu_gnt, cont_vec[i][1]);
      check($sformatf("cont%0d_en", i), ram_en, cont_vec[i][0]);
      tick();
    end

    // Loader read, then reset in the cycle of a second read issue
    ldr_req = 1; ldr_valid = 1; ldr_rw = 1; ldr_addr = 16'h0010;
    mid();
    check("lrd_en", ram_en, 1);
    check("lrd_addr", ram_addr, 16'h0010);
    tick();
    ldr_addr = 16'h000D;
    mid();
    check("lrd_lrv", ldr_rvalid, 1);
    check("lrd_crv", cpu_rvalid, 0);
    check("lrd_data", rdata, 16'h0005);
    check("lrd2_en", ram_en, 1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    ldr_valid = 0;
    rst = 1'b0;
    mid();
    check("rel_lgnt", ldr_gnt, 0);
    check("rel_lrv", ldr_rvalid, 0);
    check("rel_rdata", rdata, 0);
    tick();
    ldr_req = 0;
    mid();
    check("rel2_lgnt", ldr_gnt, 1);
    check("rel2_lrv", ldr_rvalid, 0);
    check("rel2_crv", cpu_rvalid, 0);
    check("rel2_halt", halt, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
